// File: rtl/jtframe_arb_pkg.sv
// Shared constants and FSM state type for the ROM request arbiter.
// Holds the default requester count, address width and data width.
package jtframe_arb_pkg;
  localparam int ARB_N  = 4;
  localparam int ARB_AW = 22;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Index width for N requesters; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/jtframe_romrq_arb_if.sv
// Bus bundle between the ROM requesters, the arbiter and the SDRAM controller.
// Also carries the arbiter FSM state so checkers can observe it.
interface jtframe_romrq_arb_if #(
  parameter int N  = jtframe_arb_pkg::ARB_N,
  parameter int AW = jtframe_arb_pkg::ARB_AW,
  parameter int DW = jtframe_arb_pkg::ARB_DW
);
  import jtframe_arb_pkg::*;

  logic            downloading;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    ok;
  logic [N*DW-1:0] dout;
  // sdram_req is a valid held high until the cycle sdram_ack (ready) is seen;
  // data_rdy is a one-cycle strobe qualifying data_read.
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic            data_rdy;
  logic [DW-1:0]   data_read;
  logic            refresh_en;
  arb_state_e      state;

  modport slave (
    input  downloading, req, addr, sdram_ack, data_rdy, data_read,
    output ok, dout, sdram_req, sdram_addr, refresh_en, state
  );

  modport master (
    output downloading, req, addr, sdram_ack, data_rdy, data_read,
    input  ok, dout, sdram_req, sdram_addr, refresh_en, state
  );
endinterface

// File: rtl/jtframe_romrq_slot.sv
// One-entry read cache for a single ROM requester: valid, tag and data.
// A hit raises ok combinationally; a requested miss is reported as pending.
module jtframe_romrq_slot
  import jtframe_arb_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [AW-1:0] tag_i,
  input  logic [DW-1:0] data_i,
  input  logic          req_i,
  input  logic [AW-1:0] addr_i,
  output logic          ok_o,
  output logic [DW-1:0] dout_o,
  output logic          pending_o
);
  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;
  logic          hit;

  assign hit       = valid_q && (tag_q == addr_i);
  assign ok_o      = req_i && hit;
  assign pending_o = req_i && !hit;
  assign dout_o    = data_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      tag_d   = tag_i;
      data_d  = data_i;
    end
    // A ROM download invalidates everything, even a fill landing this cycle.
    if (clr_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/jtframe_romrq_arb.sv
// Round-robin arbiter sharing one SDRAM read port between N cached requesters.
// One transaction is in flight at a time; the fill goes to the granted slot.
module jtframe_romrq_arb
  import jtframe_arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  jtframe_romrq_arb_if.slave bus
);
  localparam int IW = idx_w(N);

  arb_state_e    state_q;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] rr_q;
  logic          sdram_req_q;
  logic [AW-1:0] sdram_addr_q;

  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic          sel_vld;
  logic          complete;
  logic [N-1:0]  pending;
  logic [N-1:0]  load;
  logic [N-1:0]  ok_w;
  logic [N*DW-1:0] dout_w;
  logic [AW-1:0] addr_a [N];

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign addr_a[k] = bus.addr[k*AW +: AW];
    assign load[k]   = complete && !bus.downloading && (gnt_q == IW'(k));

    jtframe_romrq_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (bus.downloading),
      .load_i    (load[k]),
      .tag_i     (sdram_addr_q),
      .data_i    (bus.data_read),
      .req_i     (bus.req[k]),
      .addr_i    (addr_a[k]),
      .ok_o      (ok_w[k]),
      .dout_o    (dout_w[k*DW +: DW]),
      .pending_o (pending[k])
    );
  end

  // First pending slot at or after rr_q, wrapping modulo N.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(rr_q) + i) % N);
      if (!sel_vld && pending[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  assign complete = ((state_q == ST_ISSUE) && bus.sdram_ack && bus.data_rdy) ||
                    ((state_q == ST_WAIT)  && bus.data_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= '0;
      rr_q         <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_vld && !bus.downloading) begin
            gnt_q        <= sel;
            rr_q         <= IW'((int'(sel) + 1) % N);
            sdram_addr_q <= addr_a[sel];
            sdram_req_q  <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.sdram_ack) begin
            sdram_req_q <= 1'b0;
            state_q     <= bus.data_rdy ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.data_rdy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ok         = ok_w;
  assign bus.dout       = dout_w;
  assign bus.sdram_req  = sdram_req_q;
  assign bus.sdram_addr = sdram_addr_q;
  assign bus.state      = state_q;
  // Refresh is offered whenever the port is idle with nothing to fetch, and during reset.
  assign bus.refresh_en = !rst_n || ((state_q == ST_IDLE) && !(|pending));
endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Bench for jtframe_romrq_arb: scripted SDRAM controller, transaction-level cache
// model compared every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_jtframe_romrq_arb;
  import jtframe_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 22;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtframe_romrq_arb_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  jtframe_romrq_arb #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] ad);
    if (ad == 22'h1000) return 32'hCAFEBABE;
    return {10'h2A5, ad} ^ 32'h13579BDF;
  endfunction

  // ---------------- scripted SDRAM controller + grant scoreboard ----------------
  int  ack_dly   = 0;
  int  rdy_dly   = 2;
  bit  force_rdy = 1'b0;
  int  n_issue   = 0;
  logic [AW-1:0] exp_q[$];

  initial begin
    int c_phase;
    int c_cnt;
    logic [AW-1:0] c_addr;
    logic [AW-1:0] e;
    c_phase = 0;
    c_cnt   = 0;
    c_addr  = '0;
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b0;
    bus.data_read = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.sdram_ack = 1'b0;
      bus.data_rdy  = 1'b0;
      if (!rst_n) begin
        c_phase = 0;
      end else begin
        if (c_phase == 0) begin
          if (bus.sdram_req) begin
            c_addr = bus.sdram_addr;
            n_issue++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL grant_addr: got %0h expected no request", c_addr);
            end else begin
              e = exp_q.pop_front();
              chk("grant_addr", c_addr, e);
            end
            c_cnt   = ack_dly;
            c_phase = 1;
          end else if (force_rdy) begin
            bus.data_rdy  = 1'b1;
            bus.data_read = 32'hDEADBEEF;
          end
        end
        if (c_phase == 1) begin
          if (c_cnt == 0) begin
            bus.sdram_ack = 1'b1;
            if (rdy_dly == 0) begin
              bus.data_rdy  = 1'b1;
              bus.data_read = data_of(c_addr);
              c_phase = 0;
            end else begin
              c_cnt   = rdy_dly;
              c_phase = 2;
            end
          end else begin
            c_cnt--;
          end
        end else if (c_phase == 2) begin
          c_cnt--;
          if (c_cnt == 0) begin
            bus.data_rdy  = 1'b1;
            bus.data_read = data_of(c_addr);
            c_phase = 0;
          end
        end
      end
    end
  end

  // ---------------- transaction-level model ----------------
  bit            m_busy;
  bit            m_reqo;
  int            m_slot;
  int            m_rr;
  logic [AW-1:0] m_addr;
  bit            m_valid [N];
  logic [AW-1:0] m_tag   [N];
  logic [DW-1:0] m_data  [N];

  function automatic bit m_pend(input int k);
    return bus.req[k] && !(m_valid[k] && (m_tag[k] == bus.addr[k*AW +: AW]));
  endfunction

  function automatic bit m_any_pend();
    for (int k = 0; k < N; k++) if (m_pend(k)) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    bit [N-1:0] p;
    int g;
    bit acked_now;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_reqo = 0; m_rr = 0; m_slot = 0; m_addr = '0;
        for (int k = 0; k < N; k++) begin
          m_valid[k] = 0; m_tag[k] = '0; m_data[k] = '0;
        end
      end else begin
        for (int k = 0; k < N; k++) p[k] = m_pend(k);
        if (m_busy) begin
          acked_now = m_reqo && bus.sdram_ack;
          if (bus.data_rdy && (!m_reqo || acked_now)) begin
            if (!bus.downloading) begin
              m_valid[m_slot] = 1;
              m_tag[m_slot]   = m_addr;
              m_data[m_slot]  = data_of(m_addr);
            end
            m_busy = 0;
          end
          if (acked_now) m_reqo = 0;
        end else if (|p && !bus.downloading) begin
          g = -1;
          for (int i = 0; i < N; i++)
            if (g < 0 && p[(m_rr + i) % N]) g = (m_rr + i) % N;
          m_slot = g;
          m_addr = bus.addr[g*AW +: AW];
          m_busy = 1;
          m_reqo = 1;
          m_rr   = (g + 1) % N;
        end
        if (bus.downloading)
          for (int k = 0; k < N; k++) m_valid[k] = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    bit exp_ok;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        exp_ok = bus.req[k] && m_valid[k] && (m_tag[k] == bus.addr[k*AW +: AW]);
        chk($sformatf("ok[%0d]", k), bus.ok[k], exp_ok);
        if (exp_ok) chk($sformatf("dout[%0d]", k), bus.dout[k*DW +: DW], m_data[k]);
      end
      chk("sdram_req", bus.sdram_req, m_reqo);
      if (m_busy) chk("sdram_addr", bus.sdram_addr, m_addr);
      chk("fsm_idle", bus.state == ST_IDLE, !m_busy);
      chk("refresh_en", bus.refresh_en, !rst_n || (!m_busy && !m_any_pend()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] v);
    bus.addr[k*AW +: AW] = v;
  endtask

  task automatic wait_ok(input logic [N-1:0] mask, input string name, output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    while (!seen && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if ((bus.ok & mask) == mask) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: ok=%0h never reached mask %0h", name, bus.ok, mask);
    end
  endtask

  task automatic wait_issue(input int target, input string name);
    int cyc;
    cyc = 0;
    while (n_issue < target && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (n_issue < target) begin
      checks++;
      errors++;
      $display("FAIL %s: issues %0d expected %0d", name, n_issue, target);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat;
    int n0;
    bus.downloading = 1'b0;
    bus.req         = '0;
    bus.addr        = '0;

    tick(2);
    chk("rst_sdram_req",  bus.sdram_req,  1'b0);
    chk("rst_sdram_addr", bus.sdram_addr, '0);
    chk("rst_refresh_en", bus.refresh_en, 1'b1);
    chk("rst_ok",         bus.ok,         '0);
    chk("rst_dout",       bus.dout,       '0);
    rst_n = 1'b1;
    tick(1);

    // Hit/miss on slot 0.
    n0 = n_issue;
    set_addr(0, 22'h1000);
    exp_q.push_back(22'h1000);
    bus.req = 4'b0001;
    wait_ok(4'b0001, "t1_ok0", lat);
    chk("t1_latency", lat, 4);
    chk("t1_dout0", bus.dout[31:0], 32'hCAFEBABE);
    chk("t1_issues", n_issue - n0, 1);
    tick(6);
    chk("t1_hit_no_req", n_issue - n0, 1);
    chk("t1_ok0_hold", bus.ok[0], 1'b1);
    bus.req = '0;

    // Round-robin from a fresh pointer.
    apply_reset();
    for (int k = 0; k < N; k++) begin
      set_addr(k, AW'((k + 1) * 'h100));
      exp_q.push_back(AW'((k + 1) * 'h100));
    end
    bus.req = 4'hF;
    wait_ok(4'hF, "t2_all_ok", lat);
    chk("t2_q_drained", exp_q.size(), 0);
    tick(1);
    set_addr(0, 22'h500);
    set_addr(3, 22'h700);
    exp_q.push_back(22'h500);
    exp_q.push_back(22'h700);
    wait_ok(4'hF, "t2_wrap_ok", lat);
    chk("t2_wrap_drained", exp_q.size(), 0);

    // Stray data_rdy while idle must not touch any slot.
    tick(1);
    n0 = n_issue;
    force_rdy = 1'b1;
    tick(1);
    force_rdy = 1'b0;
    tick(2);
    chk("stray_no_issue", n_issue - n0, 0);
    chk("stray_ok_all", bus.ok, 4'hF);

    // Address change while slot 1 is in flight.
    rdy_dly = 4;
    n0 = n_issue;
    set_addr(1, 22'h2000);
    exp_q.push_back(22'h2000);
    exp_q.push_back(22'h2004);
    wait_issue(n0 + 1, "t3_first_issue");
    tick(1);
    set_addr(1, 22'h2004);
    wait_ok(4'b0010, "t3_ok1", lat);
    chk("t3_issues", n_issue - n0, 2);
    chk("t3_dout1", bus.dout[63:32], 32'hBA17BBDB);

    // Ack and data_rdy in the same ISSUE cycle.
    tick(1);
    ack_dly = 1;
    rdy_dly = 0;
    set_addr(2, 22'h3000);
    exp_q.push_back(22'h3000);
    wait_ok(4'b0100, "t4_ok2", lat);
    chk("t4_latency", lat, 3);
    chk("t4_idle", bus.state, ST_IDLE);

    // Download starting while in WAIT.
    tick(1);
    ack_dly = 0;
    rdy_dly = 4;
    n0 = n_issue;
    set_addr(3, 22'h4000);
    exp_q.push_back(22'h4000);
    wait_issue(n0 + 1, "t5_issue");
    tick(1);
    bus.downloading = 1'b1;
    tick(8);
    chk("t5_ok_clear", bus.ok, '0);
    chk("t5_no_grant", n_issue - n0, 1);
    chk("t5_idle", bus.state, ST_IDLE);
    bus.req = '0;
    #1;
    chk("t5_refresh", bus.refresh_en, 1'b1);
    tick(1);
    bus.downloading = 1'b0;
    rdy_dly = 1;
    exp_q.push_back(22'h500);
    exp_q.push_back(22'h2004);
    exp_q.push_back(22'h3000);
    exp_q.push_back(22'h4000);
    bus.req = 4'hF;
    wait_ok(4'hF, "t5_refill", lat);

    // Reset in the middle of ISSUE.
    tick(1);
    ack_dly = 8;
    n0 = n_issue;
    bus.req = 4'b0010;
    set_addr(1, 22'h2100);
    exp_q.push_back(22'h2100);
    wait_issue(n0 + 1, "t6_issue");
    tick(1);
    set_addr(0, 22'h600);
    set_addr(2, 22'h3100);
    bus.req = 4'b0111;
    @(posedge clk);
    #4 rst_n = 1'b0;
    #0.5;
    chk("t6_sdram_req", bus.sdram_req, 1'b0);
    chk("t6_ok", bus.ok, '0);
    chk("t6_refresh", bus.refresh_en, 1'b1);
    chk("t6_sdram_addr", bus.sdram_addr, '0);
    chk("t6_dout", bus.dout, '0);
    ack_dly = 0;
    rdy_dly = 1;
    exp_q.push_back(22'h600);
    exp_q.push_back(22'h2100);
    exp_q.push_back(22'h3100);
    tick(2);
    rst_n = 1'b1;
    wait_ok(4'b0111, "t6_refill", lat);

    tick(5);
    chk("final_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtframe_romrq_arb.md
JTFRAME_ROMRQ_ARB -- requirements
Module: jtframe_romrq_arb

Interface
REQ-001 SHALL have parameter N, default 4: number of ROM requesters.
REQ-002 SHALL have parameter AW, default 22: SDRAM word address width.
REQ-003 SHALL have parameter DW, default 32: SDRAM read data width.
REQ-004 Ports SHALL be:
- clk, in, 1: single system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- downloading, in, 1: ROM download in progress.
- req, in, N: per-requester read request, level.
- addr, in, N*AW: per-requester address; slot k is at [k*AW +: AW].
- ok, out, N: dout slot k is valid for addr slot k.
- dout, out, N*DW: per-requester read data.
- sdram_req, out, 1: read request to the SDRAM controller.
- sdram_addr, out, AW: address of the granted request.
- sdram_ack, in, 1: controller accepted sdram_req.
- data_rdy, in, 1: data_read is valid this cycle.
- data_read, in, DW: SDRAM read data.
- refresh_en, out, 1: controller may refresh.

Function
REQ-005 Each slot SHALL hold a one-entry cache: valid bit, AW-bit tag, DW-bit data.
REQ-006 ok[k] SHALL be combinational: req[k] & valid[k] & (tag[k]==addr[k]).
REQ-007 A slot SHALL be pending when req[k] is high and its cache misses.
REQ-008 FSM states SHALL be IDLE, ISSUE and WAIT; IDLE SHALL be the reset state.
REQ-009 In IDLE with any slot pending and downloading low, the arbiter SHALL grant the first pending slot at or after rr_ptr, searching round-robin with modulo-N wrap.
- Same cycle: latch the grant index and addr into sdram_addr.
- Next cycle: assert sdram_req and enter ISSUE.
REQ-010 rr_ptr SHALL advance to (grant+1) mod N on each grant.
REQ-011 In ISSUE, sdram_req SHALL stay high until sdram_ack.
- On the ack cycle: sdram_req falls and the FSM enters WAIT.
- If data_rdy is also high that cycle, the transaction completes directly and the FSM returns to IDLE.
REQ-012 In WAIT, data_rdy SHALL complete the transaction and the FSM SHALL return to IDLE.
- data_rdy outside ISSUE/WAIT SHALL be ignored.
REQ-013 On completion, the granted slot SHALL load valid=1, tag=latched sdram_addr and data=data_read.
- ok may therefore rise one cycle after data_rdy.
- Minimum miss-to-ok latency: 3 cycles plus controller latency.
REQ-014 If addr[k] changes while its transaction is in flight, the cache SHALL still store the issued tag.
- ok[k] stays low and slot k becomes pending again.
REQ-015 sdram_addr SHALL stay stable from grant until completion.
REQ-016 refresh_en SHALL be high only in IDLE with no pending slot.
REQ-017 While downloading is high:
- All valid bits clear every cycle.
- No new grant is made.
- An in-flight transaction runs to completion, but its data is discarded.
REQ-018 A requester dropping req mid-transaction SHALL NOT abort the SDRAM cycle; the data is still cached.
REQ-019 A cache hit SHALL NOT generate an SDRAM request.

Reset
REQ-020 Asserting rst_n low SHALL immediately set the following, at any time including mid-transaction:
- FSM to IDLE.
- sdram_req=0, sdram_addr=0.
- rr_ptr=0.
- All valid bits, tags and dout to 0.
- refresh_en=1.
- ok=0.
REQ-021 After rst_n rises, the first grant SHALL occur no earlier than the first clk edge.

Structure
REQ-022 The FSM state enum and the default N/AW/DW constants SHALL be in the shared package jtframe_arb_pkg.
REQ-023 The per-slot cache (valid/tag/data, hit compare, ok) SHALL be the sub-module jtframe_romrq_slot, instantiated N times.

Verification
REQ-024 Hit/miss: slot0 req at 0x1000 with a 2-cycle controller and data_read=0xCAFEBABE -> exactly one sdram_req; ok[0] rises one cycle after data_rdy with dout0=0xCAFEBABE; a repeat at 0x1000 gives no new sdram_req.
REQ-025 Round-robin: all four slots miss simultaneously with rr_ptr=0 -> grants in order 0,1,2,3; then slots 0 and 3 miss again -> slot 0 is granted first (pointer wrapped to 0).
REQ-026 Address change in flight: slot1 issues 0x2000, and addr changes to 0x2004 before data_rdy -> ok[1] stays low and a second sdram_req at 0x2004 follows.
REQ-027 Simultaneous ack and rdy: sdram_ack and data_rdy in the same ISSUE cycle -> FSM back in IDLE the next cycle and the cache loaded.
REQ-028 Download: downloading rises while in WAIT -> the transaction completes, ok stays 0, no grants while high, refresh_en=1 once idle.
REQ-029 Reset mid-ISSUE: rst_n pulled low -> sdram_req=0 and ok=0 asynchronously; the post-reset first grant goes to the lowest pending slot.
